axi_sync_fifo_bank: RTL and testbench
=====================================

AXI_SYNC_FIFO_BANK -- requirements
Module: axi_sync_fifo_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 16, entries per channel; power of two, >= 2.
REQ-003 SHALL have parameter NUM_CH, default 4, independent channels; 1..8.
REQ-004 SHALL have parameter AF_LVL, default DEPTH-2, almost-full threshold (count >= AF_LVL).
REQ-005 SHALL have parameter AE_LVL, default 2, almost-empty threshold (count <= AE_LVL).
REQ-006 SHALL have port AXI_CLK, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port ARESETn, input, 1, synchronous active-low reset.
REQ-008 SHALL have port PUSH, input, NUM_CH, per-channel write request.
REQ-009 SHALL have port WR_DATA, input, NUM_CH*WIDTH, channel c at bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port POP, input, NUM_CH, per-channel read acknowledge.
REQ-011 SHALL have port RD_DATA, output, NUM_CH*WIDTH, first-word-fall-through head per channel.
REQ-012 SHALL have port FLUSH, input, NUM_CH, per-channel synchronous clear.
REQ-013 SHALL have port ERR_CLR, input, NUM_CH, clears the sticky error flags.
REQ-014 SHALL have ports FULL, EMPTY, AFULL, AEMPTY, output, NUM_CH each, status flags.
REQ-015 SHALL have port COUNT, output, NUM_CH*$clog2(DEPTH+1), per-channel occupancy.
REQ-016 SHALL have ports OVF and UDF, output, NUM_CH each, sticky overflow and underflow flags.

Function
REQ-017 Channels SHALL be fully independent; no input of channel c affects channel k != c.
REQ-018 A push SHALL be accepted when PUSH[c]=1 and either FULL[c]=0, or FULL[c]=1 with POP[c]=1 in the same cycle.
REQ-019 A pop SHALL be accepted when POP[c]=1 and EMPTY[c]=0.
REQ-020 COUNT SHALL change by +1 (push only), -1 (pop only), or 0 (both or neither), registered, with 1-cycle latency.
REQ-021 RD_DATA SHALL present the oldest entry whenever EMPTY=0; a pushed word SHALL appear on RD_DATA the cycle after the push if the channel was empty.
REQ-022 RD_DATA SHALL hold its last value while EMPTY=1; it is don't-care for checking.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without gaps.
REQ-024 FULL = (COUNT==DEPTH), EMPTY = (COUNT==0), AFULL = (COUNT>=AF_LVL), AEMPTY = (COUNT<=AE_LVL); all SHALL be derived from the registered count, glitch-free.
REQ-025 Push with FULL=1 and POP=0 SHALL be dropped, leave the storage unchanged, and set OVF[c] on the next edge.
REQ-026 Pop with EMPTY=1 SHALL be ignored and set UDF[c] on the next edge; a simultaneous push SHALL still be accepted.
REQ-027 OVF/UDF SHALL remain set until ERR_CLR[c]=1; if a set event and ERR_CLR occur in the same cycle, the flag SHALL be set.
REQ-028 FLUSH[c]=1 SHALL zero that channel's pointers and COUNT on the next edge and SHALL override PUSH/POP in the same cycle; OVF/UDF SHALL be unaffected.

Reset
REQ-029 With ARESETn=0 at an edge, every channel SHALL take COUNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0 (unless AF_LVL=0), OVF=0, UDF=0, pointers=0.
REQ-030 RD_DATA SHALL reset to 0; storage array contents need no reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries; PUSH/POP in reset cycles SHALL have no effect.

Structure
REQ-032 A shared package axi_sdram_pkg SHALL hold the default WIDTH/DEPTH/NUM_CH localparams and a function computing the count width.
REQ-033 Per-channel logic SHALL live in one sub-module sync_fifo_ch, instantiated NUM_CH times through a generate loop.
REQ-034 Elaboration SHALL fail if DEPTH is not a power of two or if AE_LVL >= AF_LVL.

Verification
REQ-035 Fill ch0 with 16 pushes 0x00..0x0F (DEPTH=16) -> FULL[0]=1, COUNT[0]=16, AFULL from count 14; other channels EMPTY=1.
REQ-036 17th push to a full ch0 with POP=0 -> OVF[0]=1, COUNT=16; 16 pops return 0x00..0x0F in order; ERR_CLR -> OVF=0.
REQ-037 Full ch1 with simultaneous PUSH=0xAA and POP -> COUNT stays 16, OVF=0, 0xAA read as the 16th word after the original 15.
REQ-038 Pop on an empty ch2 with simultaneous push 0x55 -> UDF[2]=1, COUNT=1, RD_DATA[2]=0x55 on the next cycle.
REQ-039 Push 40 words with interleaved pops on ch3 -> pointers wrap twice with no data loss; reference-model compare passes.
REQ-040 FLUSH on ch0 together with PUSH while COUNT=5, then ARESETn=0 mid-burst -> COUNT=0, EMPTY=1, the pushed word is discarded, flags as in REQ-029.

Source files
------------

// File: rtl/axi_sdram_pkg.sv
// Shared defaults and helpers for the synchronous FIFO bank.
package axi_sdram_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_NUM_CH = 4;

  // Occupancy ranges 0..depth inclusive, so one extra code is needed.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// One independent FWFT FIFO channel with registered status flags and sticky errors.
module sync_fifo_ch
  import axi_sdram_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2,
  parameter int unsigned CW     = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf_set;
  logic             udf_set;

  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop);
    ovf_set    = push && full && !pop;
    udf_set    = pop && empty;
    rd_ptr_nxt = rd_ptr + PW'(pop_ok);
    count_nxt  = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (flush) count_nxt = '0;
    // The head register is preloaded with the next oldest word; when that
    // slot is the one being written this cycle, bypass straight from wr_data.
    head_nxt = rd_data;
    if (!flush && count_nxt != '0) begin
      if (push_ok && rd_ptr_nxt == wr_ptr) head_nxt = wr_data;
      else                                 head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      afull   <= (AF_LVL == 0);
      aempty  <= 1'b1;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push_ok);
        rd_ptr <= rd_ptr_nxt;
      end
      count   <= count_nxt;
      rd_data <= head_nxt;
      full    <= (count_nxt == DEPTH_C);
      empty   <= (count_nxt == '0);
      afull   <= (count_nxt >= AF_C);
      aempty  <= (count_nxt <= AE_C);
      ovf     <= ovf_set || (ovf && !err_clr);
      udf     <= udf_set || (udf && !err_clr);
    end
  end

endmodule

// File: rtl/axi_sync_fifo_bank.sv
// Bank of NUM_CH independent synchronous FWFT FIFOs sharing one clock.
module axi_sync_fifo_bank
  import axi_sdram_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic                                 AXI_CLK,
  input  logic                                 ARESETn,
  input  logic [NUM_CH-1:0]                    PUSH,
  input  logic [NUM_CH*WIDTH-1:0]              WR_DATA,
  input  logic [NUM_CH-1:0]                    POP,
  output logic [NUM_CH*WIDTH-1:0]              RD_DATA,
  input  logic [NUM_CH-1:0]                    FLUSH,
  input  logic [NUM_CH-1:0]                    ERR_CLR,
  output logic [NUM_CH-1:0]                    FULL,
  output logic [NUM_CH-1:0]                    EMPTY,
  output logic [NUM_CH-1:0]                    AFULL,
  output logic [NUM_CH-1:0]                    AEMPTY,
  output logic [NUM_CH*cnt_width(DEPTH)-1:0]   COUNT,
  output logic [NUM_CH-1:0]                    OVF,
  output logic [NUM_CH-1:0]                    UDF
);

  localparam int unsigned CW = cnt_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_sync_fifo_bank: DEPTH must be a power of two >= 2");
  end
  if (AE_LVL >= AF_LVL) begin : g_bad_levels
    $error("axi_sync_fifo_bank: AE_LVL must be below AF_LVL");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("axi_sync_fifo_bank: NUM_CH must be 1..8");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_fifo_ch #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AF_LVL(AF_LVL),
      .AE_LVL(AE_LVL),
      .CW    (CW)
    ) u_ch (
      .clk    (AXI_CLK),
      .rst_n  (ARESETn),
      .push   (PUSH[c]),
      .wr_data(WR_DATA[c*WIDTH +: WIDTH]),
      .pop    (POP[c]),
      .flush  (FLUSH[c]),
      .err_clr(ERR_CLR[c]),
      .rd_data(RD_DATA[c*WIDTH +: WIDTH]),
      .full   (FULL[c]),
      .empty  (EMPTY[c]),
      .afull  (AFULL[c]),
      .aempty (AEMPTY[c]),
      .count  (COUNT[c*CW +: CW]),
      .ovf    (OVF[c]),
      .udf    (UDF[c])
    );
  end

endmodule

// File: tb/tb_axi_sync_fifo_bank.sv
// Directed bench for axi_sync_fifo_bank with a queue-based reference model.
module tb_axi_sync_fifo_bank;

  localparam int NCH   = 4;
  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH-1:0]    push, pop, flush, clr;
  logic [NCH*W-1:0]  wr_data;
  logic [NCH*W-1:0]  rd_data;
  logic [NCH-1:0]    full, empty, afull, aempty, ovf, udf;
  logic [NCH*CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq [NCH][$];
  bit           m_ovf [NCH];
  bit           m_udf [NCH];

  always #5 clk = ~clk;

  axi_sync_fifo_bank #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .NUM_CH(NCH),
    .AF_LVL(AF),
    .AE_LVL(AE)
  ) dut (
    .AXI_CLK(clk),
    .ARESETn(rstn),
    .PUSH   (push),
    .WR_DATA(wr_data),
    .POP    (pop),
    .RD_DATA(rd_data),
    .FLUSH  (flush),
    .ERR_CLR(clr),
    .FULL   (full),
    .EMPTY  (empty),
    .AFULL  (afull),
    .AEMPTY (aempty),
    .COUNT  (count),
    .OVF    (ovf),
    .UDF    (udf)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the cycle's inputs to the model using pre-edge occupancy.
  task automatic model_update();
    for (int c = 0; c < NCH; c++) begin
      int  sz   = mq[c].size();
      bit  mful = (sz == DEPTH);
      bit  memp = (sz == 0);
      bit  os, us;
      if (!rstn) begin
        mq[c].delete();
        m_ovf[c] = 1'b0;
        m_udf[c] = 1'b0;
      end else begin
        os = push[c] && mful && !pop[c];
        us = pop[c] && memp;
        if (flush[c]) mq[c].delete();
        else begin
          if (pop[c] && !memp) void'(mq[c].pop_front());
          if (push[c] && (!mful || pop[c])) mq[c].push_back(wr_data[c*W +: W]);
        end
        m_ovf[c] = os || (m_ovf[c] && !clr[c]);
        m_udf[c] = us || (m_udf[c] && !clr[c]);
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      int sz = mq[c].size();
      chk($sformatf("count%0d", c), W'(count[c*CW +: CW]), W'(sz));
      chk($sformatf("full%0d", c),   W'(full[c]),   W'(sz == DEPTH));
      chk($sformatf("empty%0d", c),  W'(empty[c]),  W'(sz == 0));
      chk($sformatf("afull%0d", c),  W'(afull[c]),  W'(sz >= AF));
      chk($sformatf("aempty%0d", c), W'(aempty[c]), W'(sz <= AE));
      chk($sformatf("ovf%0d", c),    W'(ovf[c]),    W'(m_ovf[c]));
      chk($sformatf("udf%0d", c),    W'(udf[c]),    W'(m_udf[c]));
      if (sz != 0) chk($sformatf("rd_data%0d", c), rd_data[c*W +: W], mq[c][0]);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
    push    = '0;
    pop     = '0;
    flush   = '0;
    clr     = '0;
    wr_data = '0;
  endtask

  task automatic wr(input int c, input logic [W-1:0] d);
    push[c] = 1'b1;
    wr_data[c*W +: W] = d;
  endtask

  initial begin
    rstn = 1'b0; push = '0; pop = '0; flush = '0; clr = '0; wr_data = '0;
    @(negedge clk);
    step();
    step();
    chk("reset_count", W'(count), '0);
    chk("reset_empty", W'(empty), W'(4'hF));
    chk("reset_aempty", W'(aempty), W'(4'hF));
    chk("reset_rd_data0", rd_data[31:0], '0);
    rstn = 1'b1;
    step();

    // Fill ch0 with 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      wr(0, W'(i));
      step();
      chk("fill_afull0", W'(afull[0]), W'(i + 1 >= 14));
    end
    chk("fill_full0", W'(full[0]), 1);
    chk("fill_count0", W'(count[CW-1:0]), 16);
    chk("fill_others_empty", W'(empty[3:1]), W'(3'b111));

    // Overflow, then drain in order, then clear
    wr(0, 32'h99);
    step();
    chk("ovf0_set", W'(ovf[0]), 1);
    chk("ovf0_count", W'(count[CW-1:0]), 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain0_word", rd_data[31:0], W'(i));
      pop[0] = 1'b1;
      step();
    end
    chk("drain0_empty", W'(empty[0]), 1);
    chk("ovf0_sticky", W'(ovf[0]), 1);
    clr[0] = 1'b1;
    step();
    chk("ovf0_cleared", W'(ovf[0]), 0);

    // Full ch1 with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      wr(1, 32'h10 + W'(i));
      step();
    end
    wr(1, 32'hAA);
    pop[1] = 1'b1;
    step();
    chk("pp1_count", W'(count[2*CW-1:CW]), 16);
    chk("pp1_ovf", W'(ovf[1]), 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("pp1_word", rd_data[63:32], (i == 15) ? 32'hAA : 32'h11 + W'(i));
      pop[1] = 1'b1;
      step();
    end

    // Underflow on empty ch2 with simultaneous push
    wr(2, 32'h55);
    pop[2] = 1'b1;
    step();
    chk("udf2_set", W'(udf[2]), 1);
    chk("udf2_count", W'(count[3*CW-1:2*CW]), 1);
    chk("udf2_rd", rd_data[95:64], 32'h55);
    pop[2] = 1'b1;
    step();
    pop[2] = 1'b1;
    clr[2] = 1'b1;
    step();
    chk("udf2_set_wins", W'(udf[2]), 1);
    clr[2] = 1'b1;
    step();
    chk("udf2_cleared", W'(udf[2]), 0);

    // ch3: 40 pushes with interleaved pops, pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      wr(3, 32'h300 + W'(i));
      if (i % 3 != 0) pop[3] = 1'b1;
      step();
    end
    chk("wrap3_count", W'(count[4*CW-1:3*CW]), 14);
    for (int i = 0; i < 14; i++) begin
      chk("wrap3_word", rd_data[127:96], 32'h300 + 32'd26 + W'(i));
      pop[3] = 1'b1;
      step();
    end
    chk("wrap3_udf", W'(udf[3]), 0);

    // Flush overrides push on ch0, then reset mid-burst
    for (int i = 0; i < 5; i++) begin
      wr(0, 32'hF0 + W'(i));
      step();
    end
    wr(0, 32'hDEAD);
    flush[0] = 1'b1;
    step();
    chk("flush0_count", W'(count[CW-1:0]), 0);
    chk("flush0_empty", W'(empty[0]), 1);
    pop[1] = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < NCH; c++) wr(c, 32'hA00 + W'(c * 16 + i));
      step();
    end
    rstn = 1'b0;
    for (int c = 0; c < NCH; c++) wr(c, 32'hBAD);
    pop = 4'hF;
    step();
    chk("rst_count", W'(count), '0);
    chk("rst_empty", W'(empty), W'(4'hF));
    chk("rst_full_afull", W'({full, afull}), '0);
    chk("rst_flags", W'({ovf, udf}), '0);
    rstn = 1'b1;
    step();
    wr(0, 32'h77);
    step();
    chk("post_rst_rd0", rd_data[31:0], 32'h77);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
